// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle for riscv_mem_arbiter: fetch port, data port and the shared memory port.
// The arbiter connects through the master modport; the pipeline/memory side uses slave.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_done_o;
  logic [DATA_W-1:0] d_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              stall_o;
  logic              err_o;

  modport master (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
    output if_done_o, if_rdata_o, d_done_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );

  modport slave (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
    input  if_done_o, if_rdata_o, d_done_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for one single-ported unified memory, with request timeout abort.
// Define ARB_FAIR_EN to force a fetch grant after MAX_DATA_RUN back-to-back data grants.
module riscv_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int MAX_DATA_RUN = 4
) (
  input logic               clk,
  input logic               rst,
  riscv_mem_arbiter_if.master bus
);

  if (TIMEOUT < 1 || MAX_DATA_RUN < 1 || ADDR_W < 1 || DATA_W < 1) begin : g_param_check
    $error("riscv_mem_arbiter: TIMEOUT, MAX_DATA_RUN, ADDR_W and DATA_W must all be >= 1");
  end

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              grant_data, grant_fetch, ack_hit, abort;
  logic              fetch_first;

  assign bus.stall_o = bus.d_req_i & ~bus.d_done_o;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    next_state  = state;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    ack_hit     = 1'b0;
    abort       = 1'b0;
    unique case (state)
      IDLE: begin
        // The done cycle still shows the finished request, so arbitration waits one more cycle.
        if (!bus.if_done_o && !bus.d_done_o) begin
          if (fetch_first)       grant_fetch = 1'b1;
          else if (bus.d_req_i)  grant_data  = 1'b1;
          else if (bus.if_req_i) grant_fetch = 1'b1;
        end
        if (grant_data)       next_state = DATA;
        else if (grant_fetch) next_state = FETCH;
      end
      DATA, FETCH: begin
        if (bus.mem_ack_i)              ack_hit = 1'b1;
        else if (wait_cnt == WAIT_LAST) abort   = 1'b1;
        if (ack_hit || abort) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.if_done_o   <= 1'b0;
      bus.d_done_o    <= 1'b0;
      bus.err_o       <= 1'b0;
      bus.if_rdata_o  <= '0;
      bus.d_rdata_o   <= '0;
      wait_cnt        <= '0;
    end else begin
      bus.if_done_o <= 1'b0;
      bus.d_done_o  <= 1'b0;
      bus.err_o     <= 1'b0;
      if (grant_data) begin
        bus.mem_req_o   <= 1'b1;
        bus.mem_we_o    <= bus.d_we_i;
        bus.mem_addr_o  <= bus.d_addr_i;
        bus.mem_wdata_o <= bus.d_wdata_i;
        wait_cnt        <= '0;
      end else if (grant_fetch) begin
        bus.mem_req_o  <= 1'b1;
        bus.mem_we_o   <= 1'b0;
        bus.mem_addr_o <= bus.if_addr_i;
        wait_cnt       <= '0;
      end else if (ack_hit || abort) begin
        bus.mem_req_o <= 1'b0;
        bus.err_o     <= abort;
        if (state == DATA) begin
          bus.d_done_o <= 1'b1;
          if (ack_hit && !bus.mem_we_o) bus.d_rdata_o <= bus.mem_rdata_i;
        end else begin
          bus.if_done_o <= 1'b1;
          if (ack_hit) bus.if_rdata_o <= bus.mem_rdata_i;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

`ifdef ARB_FAIR_EN
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  // Counts data grants that overtook a waiting fetch; saturates at MAX_DATA_RUN by forcing a fetch.
  logic [RUN_W-1:0] run_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             run_cnt <= '0;
    else if (grant_fetch) run_cnt <= '0;
    else if (grant_data)  run_cnt <= bus.if_req_i ? run_cnt + 1'b1 : '0;
  end

  assign fetch_first = bus.if_req_i && (run_cnt == RUN_W'(MAX_DATA_RUN));
`else
  assign fetch_first = 1'b0;
`endif

endmodule
